apb_master_cmd: RTL and testbench

- Parametrised APB master that turns a valid/ready command port into single APB transfers and returns a one-cycle response pulse.
- Adds what the first-generation master lacked:
  - generic address/data widths
  - byte strobes (pstrb)
  - slave error (pslverr)
  - wait-state timeout
  - optional back-to-back transfers without an IDLE cycle
- Sits between a bus-bridge/CPU-side requester and an APB slave fabric; one transfer outstanding at a time.

---
 rtl/apb_master_cmd_if.sv | 44 ++++
 rtl/apb_master_cmd.sv | 145 ++++++++++++++
 tb/tb_apb_master_cmd.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_cmd_if.sv
`default_nettype none
// ============================================================================
// apb_master_cmd_if : command/response port and APB bus of apb_master_cmd
// Rev 1.0
// ============================================================================
interface apb_master_cmd_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [DATA_W-1:0]     cmd_wdata;
  logic [DATA_W/8-1:0]   cmd_strb;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  logic [ADDR_W-1:0]     paddr;
  logic                  pwrite;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic                  psel;
  logic                  penable;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output paddr, pwrite, pwdata, pstrb, psel, penable
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  paddr, pwrite, pwdata, pstrb, psel, penable
  );
endinterface
`default_nettype wire

// File: rtl/apb_master_cmd.sv
`default_nettype none
// ============================================================================
// apb_master_cmd : valid/ready command port to single APB transfers,
//                  with strobes, slave error, wait timeout and back-to-back
// Rev 1.0
// ============================================================================
module apb_master_cmd #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int TIMEOUT   = 16,
  parameter int BACK2BACK = 1
) (
  input logic              pclk,
  input logic              prst,
  apb_master_cmd_if.master bus
);
  localparam int c_strb_w = DATA_W / 8;
  localparam int c_cnt_w  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_setup  = 2'd1;
  localparam logic [1:0] c_st_access = 2'd2;

  logic [1:0]          r_state;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [ADDR_W-1:0]   r_paddr;
  logic                r_pwrite;
  logic [DATA_W-1:0]   r_pwdata;
  logic [c_strb_w-1:0] r_pstrb;
  logic                r_psel;
  logic                r_penable;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic                r_rsp_timeout;

  logic w_in_access;
  logic w_tmo;
  logic w_done;
  logic w_ready;
  logic w_accept;

  assign w_in_access = (r_state == c_st_access);

  // The counter starts at 0 on the first ACCESS cycle, so aborting at
  // TIMEOUT-1 gives the slave exactly TIMEOUT ACCESS cycles.
  generate
    if (TIMEOUT != 0) begin : g_tmo
      localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT - 1);
      assign w_tmo = w_in_access && !bus.pready && (r_cnt == c_tmo_last);
    end else begin : g_no_tmo
      assign w_tmo = 1'b0;
    end
  endgenerate

  assign w_done = w_in_access && (bus.pready || w_tmo);

  generate
    if (BACK2BACK != 0) begin : g_b2b
      assign w_ready = !prst && ((r_state == c_st_idle) || w_done);
    end else begin : g_no_b2b
      assign w_ready = !prst && (r_state == c_st_idle);
    end
  endgenerate

  assign w_accept = bus.cmd_valid && w_ready;

  always_ff @(posedge pclk) begin
    if (prst) begin
      r_state       <= c_st_idle;
      r_cnt         <= '0;
      r_paddr       <= '0;
      r_pwrite      <= 1'b0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      case (r_state)
        c_st_idle: begin
          r_pstrb <= '0;
        end
        c_st_setup: begin
          r_state   <= c_st_access;
          r_penable <= 1'b1;
          r_cnt     <= '0;
        end
        c_st_access: begin
          if (w_done) begin
            r_rsp_valid <= 1'b1;
            if (bus.pready) begin
              r_rsp_err   <= bus.pslverr;
              r_rsp_rdata <= r_pwrite ? '0 : bus.prdata;
            end else begin
              r_rsp_err     <= 1'b1;
              r_rsp_timeout <= 1'b1;
            end
            r_state   <= c_st_idle;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pstrb   <= '0;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        default: begin
          r_state   <= c_st_idle;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
      endcase
      // An accepted command overrides the return to IDLE chosen above.
      if (w_accept) begin
        r_state   <= c_st_setup;
        r_paddr   <= bus.cmd_addr;
        r_pwrite  <= bus.cmd_write;
        r_pwdata  <= bus.cmd_wdata;
        r_pstrb   <= bus.cmd_write ? bus.cmd_strb : '0;
        r_psel    <= 1'b1;
        r_penable <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready   = w_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.paddr       = r_paddr;
  assign bus.pwrite      = r_pwrite;
  assign bus.pwdata      = r_pwdata;
  assign bus.pstrb       = r_pstrb;
  assign bus.psel        = r_psel;
  assign bus.penable     = r_penable;
endmodule
`default_nettype wire

// File: tb/tb_apb_master_cmd.sv
`default_nettype none
// ============================================================================
// tb_apb_master_cmd : directed table, hand sequences and random traffic
// Rev 1.0
// ============================================================================
module tb_apb_master_cmd;
  localparam int AW  = 4;
  localparam int DW  = 16;
  localparam int SW  = 2;
  localparam int TMO = 4;

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  strb;
    int          waits;
    bit          slverr;
    logic [15:0] rdata;
  } cmd_t;

  typedef struct {
    bit          err;
    bit          tmo;
    logic [15:0] rdata;
    int          nacc;
    int          rsp_cyc;
  } exp_t;

  typedef struct {
    cmd_t c;
    exp_t e;
  } vec_t;

  logic clk  = 1'b0;
  logic prst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  int   last_acc = 0;
  int   acc_cnt = 0;
  cmd_t cur;
  exp_t me;
  cmd_t planq[$];
  exp_t expq[$];
  bit   psel_log[0:4095];
  bit   pen_log[0:4095];

  apb_master_cmd_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();
  apb_master_cmd_if #(.ADDR_W(AW), .DATA_W(DW)) ifc2 ();

  apb_master_cmd #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .BACK2BACK(1)) u_dut (
    .pclk(clk), .prst(prst), .bus(ifc)
  );
  apb_master_cmd #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(0), .BACK2BACK(0)) u_dut_nb (
    .pclk(clk), .prst(prst), .bus(ifc2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic cmd_t mk(bit wr, logic [3:0] a, logic [15:0] wd, logic [1:0] s,
                              int w, bit se, logic [15:0] rd);
    cmd_t c;
    c.wr = wr; c.addr = a; c.wdata = wd; c.strb = s;
    c.waits = w; c.slverr = se; c.rdata = rd;
    return c;
  endfunction

  function automatic exp_t mke(bit err, bit tmo, logic [15:0] rd, int n);
    exp_t e;
    e.err = err; e.tmo = tmo; e.rdata = rd; e.nacc = n; e.rsp_cyc = 0;
    return e;
  endfunction

  // Transaction-level expectation: a slave waiting TMO or more cycles is cut off.
  function automatic exp_t model(cmd_t c);
    if (TMO != 0 && c.waits >= TMO) return mke(1'b1, 1'b1, 16'h0, TMO);
    return mke(c.slverr, 1'b0, c.wr ? 16'h0 : c.rdata, c.waits + 1);
  endfunction

  task automatic send(input cmd_t c, input exp_t e);
    int guard;
    guard = 0;
    @(negedge clk);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_write = c.wr;
    ifc.cmd_addr  = c.addr;
    ifc.cmd_wdata = c.wdata;
    ifc.cmd_strb  = c.strb;
    #1;
    while (!ifc.cmd_ready && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!ifc.cmd_ready) begin
      chk("accept_wait", 32'd0, 32'd1);
      ifc.cmd_valid = 1'b0;
      return;
    end
    last_acc  = cyc;
    e.rsp_cyc = cyc + 2 + e.nacc;
    expq.push_back(e);
    planq.push_back(c);
  endtask

  task automatic idle();
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (expq.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_outstanding", expq.size(), 0);
  endtask

  always @(negedge clk) begin
    if (cyc < 4096) begin
      psel_log[cyc] <= ifc.psel;
      pen_log[cyc]  <= ifc.penable;
    end
  end

  // Response scoreboard first, then the APB slave model for this cycle.
  always @(negedge clk) begin
    if (mon_en && !prst) begin
      if (ifc.rsp_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          me = expq.pop_front();
          chk("rsp_err", ifc.rsp_err, me.err);
          chk("rsp_timeout", ifc.rsp_timeout, me.tmo);
          chk("rsp_rdata", ifc.rsp_rdata, me.rdata);
          chk("rsp_latency", cyc, me.rsp_cyc);
          chk("access_cycles", acc_cnt, me.nacc);
          chk("psel_after_rsp", {ifc.psel, ifc.penable}, {expq.size() > 0, 1'b0});
        end
      end else begin
        chk("rsp_idle_zero", {ifc.rsp_err, ifc.rsp_timeout}, 2'b00);
      end
      if (!ifc.psel) chk("idle_pstrb_penable", {ifc.pstrb, ifc.penable}, 3'b000);
      if (ifc.psel && !ifc.penable) begin
        if (planq.size() == 0) begin
          chk("setup_without_cmd", 32'd1, 32'd0);
        end else begin
          cur = planq.pop_front();
          acc_cnt = 0;
          chk("setup_fields", {ifc.paddr, ifc.pwrite, ifc.pwdata, ifc.pstrb},
              {cur.addr, cur.wr, cur.wdata, cur.wr ? cur.strb : 2'b00});
        end
      end else if (ifc.psel && ifc.penable) begin
        chk("access_stable", {ifc.paddr, ifc.pwrite, ifc.pwdata, ifc.pstrb},
            {cur.addr, cur.wr, cur.wdata, cur.wr ? cur.strb : 2'b00});
      end
    end
    if (ifc.psel && ifc.penable && !prst) begin
      ifc.pready  = (acc_cnt >= cur.waits);
      ifc.pslverr = cur.slverr;
      ifc.prdata  = cur.rdata;
      acc_cnt++;
    end else begin
      ifc.pready  = 1'($urandom);
      ifc.pslverr = 1'($urandom);
      ifc.prdata  = 16'($urandom);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vt[8];
    cmd_t       z;
    cmd_t       r;
    int         first;
    int         g;
    logic [5:0] nb_psel;
    logic [5:0] nb_pen;
    logic [5:0] nb_rsp;
    logic [5:0] nb_rdy;

    vt[0].c = mk(1'b1, 4'h5, 16'h00A3, 2'b01, 0, 1'b0, 16'h0000);
    vt[0].e = mke(1'b0, 1'b0, 16'h0000, 1);
    vt[1].c = mk(1'b0, 4'h2, 16'h1234, 2'b11, 2, 1'b0, 16'h003C);
    vt[1].e = mke(1'b0, 1'b0, 16'h003C, 3);
    vt[2].c = mk(1'b1, 4'h7, 16'h0F0F, 2'b10, 0, 1'b1, 16'hFFFF);
    vt[2].e = mke(1'b1, 1'b0, 16'h0000, 1);
    vt[3].c = mk(1'b0, 4'hC, 16'h0000, 2'b00, 99, 1'b0, 16'hAAAA);
    vt[3].e = mke(1'b1, 1'b1, 16'h0000, 4);
    vt[4].c = mk(1'b0, 4'h9, 16'h0000, 2'b01, 1, 1'b1, 16'hBEEF);
    vt[4].e = mke(1'b1, 1'b0, 16'hBEEF, 2);
    vt[5].c = mk(1'b1, 4'hF, 16'h5A5A, 2'b11, 3, 1'b0, 16'h0000);
    vt[5].e = mke(1'b0, 1'b0, 16'h0000, 4);
    vt[6].c = mk(1'b0, 4'h3, 16'h0000, 2'b00, 4, 1'b0, 16'h1111);
    vt[6].e = mke(1'b1, 1'b1, 16'h0000, 4);
    vt[7].c = mk(1'b1, 4'h0, 16'hFFFF, 2'b11, 0, 1'b0, 16'h0000);
    vt[7].e = mke(1'b0, 1'b0, 16'h0000, 1);

    ifc.cmd_valid  = 1'b1;
    ifc.cmd_write  = 1'b0;
    ifc.cmd_addr   = '0;
    ifc.cmd_wdata  = '0;
    ifc.cmd_strb   = '0;
    ifc2.cmd_valid = 1'b0;
    ifc2.cmd_write = 1'b1;
    ifc2.cmd_addr  = 4'h1;
    ifc2.cmd_wdata = 16'hC0DE;
    ifc2.cmd_strb  = 2'b11;
    ifc2.pready    = 1'b0;
    ifc2.pslverr   = 1'b0;
    ifc2.prdata    = '0;

    prst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctrl", {ifc.psel, ifc.penable, ifc.pwrite, ifc.rsp_valid, ifc.rsp_err, ifc.rsp_timeout}, 6'd0);
    chk("reset_bus", {ifc.paddr, ifc.pwdata, ifc.pstrb}, 22'd0);
    chk("reset_rdata", ifc.rsp_rdata, 16'd0);
    chk("reset_ready_low", {ifc.cmd_ready, ifc2.cmd_ready}, 2'b00);
    ifc.cmd_valid = 1'b0;
    prst   = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    #1;
    chk("ready_after_reset", ifc.cmd_ready, 1'b1);

    for (int i = 0; i < 8; i++) begin
      send(vt[i].c, vt[i].e);
      idle();
      drain();
    end

    z = mk(1'b1, 4'h6, 16'h1111, 2'b11, 0, 1'b0, 16'h0000);
    send(z, model(z));
    first = last_acc;
    z.addr = 4'h7;
    send(z, model(z));
    z.addr = 4'h8;
    send(z, model(z));
    idle();
    drain();
    for (int k = 1; k <= 6; k++) begin
      chk("b2b_psel", psel_log[first + k], 1'b1);
      chk("b2b_penable", pen_log[first + k], (k % 2) == 0);
    end
    chk("b2b_psel_end", psel_log[first + 7], 1'b0);

    z = mk(1'b0, 4'hA, 16'h0000, 2'b00, 99, 1'b0, 16'h7777);
    send(z, model(z));
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    prst = 1'b1;
    @(negedge clk);
    #1;
    chk("midreset_psel_penable", {ifc.psel, ifc.penable}, 2'b00);
    chk("midreset_no_rsp", ifc.rsp_valid, 1'b0);
    chk("midreset_ready_low", ifc.cmd_ready, 1'b0);
    expq.delete();
    planq.delete();
    @(negedge clk);
    prst = 1'b0;
    #1;
    chk("postreset_no_rsp", ifc.rsp_valid, 1'b0);
    send(vt[0].c, vt[0].e);
    idle();
    drain();

    for (int i = 0; i < 120; i++) begin
      r = mk(1'($urandom), 4'($urandom), 16'($urandom), 2'($urandom),
             int'($urandom_range(0, 6)), 1'($urandom), 16'($urandom));
      send(r, model(r));
      g = int'($urandom_range(0, 2));
      repeat (g) idle();
    end
    idle();
    drain();

    nb_psel = 6'b011011;
    nb_pen  = 6'b010010;
    nb_rsp  = 6'b100100;
    nb_rdy  = 6'b100100;
    ifc2.pready = 1'b1;
    @(negedge clk);
    ifc2.cmd_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk("nb_psel", ifc2.psel, nb_psel[k]);
      chk("nb_penable", ifc2.penable, nb_pen[k]);
      chk("nb_rsp_valid", ifc2.rsp_valid, nb_rsp[k]);
      chk("nb_cmd_ready", ifc2.cmd_ready, nb_rdy[k]);
    end
    ifc2.cmd_valid = 1'b0;
    ifc2.pready    = 1'b0;
    @(negedge clk);
    ifc2.cmd_valid = 1'b1;
    @(negedge clk);
    ifc2.cmd_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      #1;
      chk("nb_notimeout_hold", {ifc2.psel, ifc2.penable, ifc2.rsp_valid}, 3'b110);
    end
    ifc2.pready = 1'b1;
    @(negedge clk);
    #1;
    chk("nb_late_rsp", {ifc2.rsp_valid, ifc2.rsp_err, ifc2.rsp_timeout, ifc2.psel}, 4'b1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
